// File: rtl/spm_loader_pkg.sv
// Shared definitions for the RISC_SPM program loader: register offsets, FSM encoding, STATUS layout.
// Pure declarations, no logic.
package spm_loader_pkg;

    localparam logic [3:0] CTRL   = 4'h0;
    localparam logic [3:0] PUSH   = 4'h4;
    localparam logic [3:0] STATUS = 4'h8;
    localparam logic [3:0] CSUM   = 4'hC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_BUSY  = 3;
    localparam int ST_LVL   = 4;

endpackage

// File: rtl/spm_program_loader_if.sv
// Wishbone slave bus of the program loader; master drives the request, slave returns ack/data.
// Ack arrives one cycle after the request and never on two consecutive cycles.
interface spm_program_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/spm_loader_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a pushed entry is visible the next cycle.
// A push while full is accepted only when a pop happens in the same cycle, otherwise ignored.
module spm_loader_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign level   = count;
    assign pop_dat = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // When full, the slot being pushed is the one being popped this cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spm_program_loader.sv
// Wishbone-fed loader writing {addr,data} pairs into RISC_SPM, 4 cycles per entry; ack 1 cycle after request.
// Full FIFO drops pushes (sticky overflow); CSUM accumulator exists only with SPM_LOADER_CSUM_EN.
module spm_program_loader
    import spm_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    spm_program_loader_if.slave wb,
    output logic                spm_rst,
    output logic                spm_ext_write,
    output logic [ADDR_W-1:0]   spm_address,
    output logic [DATA_W-1:0]   spm_data,
    output logic                busy
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              hold_q;
    logic              run_q;
    logic              ovf_q;
    state_t            state_q;
    state_t            state_d;

    logic [ENT_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    logic [1:0]        reg_sel;
    logic              access;
    logic              wr_en;
    logic              rd_en;
    logic              push;
    logic              pop;
    logic [31:0]       status_word;
    logic [31:0]       csum_word;
    logic [31:0]       rd_word;
    logic              unused_in;

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    // The ~ack_q term keeps a held strobe from being taken twice.
    assign access  = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
    assign wr_en   = access &  wb.wbs_we_i;
    assign rd_en   = access & ~wb.wbs_we_i;
    assign reg_sel = wb.wbs_adr_i[3:2];
    assign push    = wr_en && (reg_sel == PUSH[3:2]);
    assign pop     = (state_q == IDLE) && !fifo_empty;

    assign unused_in = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:ADDR_W+8]};

    spm_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({wb.wbs_dat_i[8 +: ADDR_W], wb.wbs_dat_i[0 +: DATA_W]}),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign busy    = ~fifo_empty | (state_q != IDLE);
    assign spm_rst = hold_q | ~run_q | busy;

    always_comb begin
        status_word               = '0;
        status_word[ST_EMPTY]     = fifo_empty;
        status_word[ST_FULL]      = fifo_full;
        status_word[ST_OVF]       = ovf_q;
        status_word[ST_BUSY]      = busy;
        status_word[ST_LVL +: 4]  = 4'(fifo_level);
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            CTRL[3:2]:   rd_word = {30'b0, run_q, hold_q};
            STATUS[3:2]: rd_word = status_word;
            CSUM[3:2]:   rd_word = csum_word;
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= access;
            dat_q <= rd_en ? rd_word : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            run_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == CTRL[3:2])) begin
                {run_q, hold_q} <= wb.wbs_dat_i[1:0];
            end
            if (push && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end else if (wr_en && (reg_sel == STATUS[3:2]) && wb.wbs_dat_i[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        spm_ext_write = 1'b0;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE: begin
                spm_ext_write = 1'b1;
                state_d       = HOLD;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/data are captured on the pop and stay put until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spm_address <= '0;
            spm_data    <= '0;
        end else if (pop) begin
            {spm_address, spm_data} <= fifo_head;
        end
    end

`ifdef SPM_LOADER_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (wr_en && (reg_sel == CSUM[3:2])) begin
            csum_q <= '0;
        end else if (state_q == STROBE) begin
            csum_q <= csum_q + 8'(spm_data);
        end
    end

    assign csum_word = {24'b0, csum_q};
`else
    assign csum_word = '0;
`endif

endmodule

// File: tb/tb_spm_program_loader.sv
// Randomized bench for spm_program_loader: queue-based reference model, scoreboard of expected SPM writes and reads.
module tb_spm_program_loader;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       spm_rst;
    logic       spm_ext_write;
    logic [7:0] spm_address;
    logic [7:0] spm_data;
    logic       busy;

    always #5 clk = ~clk;

    spm_program_loader_if bus();

    spm_program_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb            (bus),
        .spm_rst       (spm_rst),
        .spm_ext_write (spm_ext_write),
        .spm_address   (spm_address),
        .spm_data      (spm_data),
        .busy          (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending-entry queue, a count of cycles the writer is still occupied,
    // and plain register variables.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    ent_t        m_q[$];
    ent_t        sb_q[$];
    logic [31:0] rd_q[$];
    int          m_cnt    = 0;
    logic [1:0]  m_ctrl   = 2'b00;
    bit          m_ovf    = 1'b0;
    bit          m_ack    = 1'b0;
    bit          m_ack_rd = 1'b0;
    ent_t        m_cur    = '0;
    logic [7:0]  m_csum   = 8'h00;

    function automatic bit model_busy();
        return (m_q.size() != 0) || (m_cnt != 0);
    endfunction

    function automatic bit model_rst();
        return m_ctrl[0] || !m_ctrl[1] || model_busy();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit          acc;
        bit          wr;
        bit          pop;
        int          ix;
        int          lvl;
        logic [31:0] rv;
        ent_t        e;
        if (!rst_n) begin
            m_q.delete();
            sb_q.delete();
            rd_q.delete();
            m_cnt    = 0;
            m_ctrl   = 2'b00;
            m_ovf    = 1'b0;
            m_ack    = 1'b0;
            m_ack_rd = 1'b0;
            m_cur    = '0;
            m_csum   = 8'h00;
        end else begin
            acc = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack;
            wr  = acc && bus.wbs_we_i;
            ix  = int'(bus.wbs_adr_i[3:2]);
            lvl = m_q.size();
            pop = (m_cnt == 0) && (lvl > 0);
            if (acc && !wr) begin
                case (ix)
                    0:       rv = {30'b0, m_ctrl};
                    2:       rv = {24'b0, 4'(lvl), model_busy(), m_ovf, lvl == 8, lvl == 0};
`ifdef SPM_LOADER_CSUM_EN
                    3:       rv = {24'b0, m_csum};
`endif
                    default: rv = 32'h0;
                endcase
                rd_q.push_back(rv);
            end
`ifdef SPM_LOADER_CSUM_EN
            if (wr && ix == 3) m_csum = 8'h00;
            else if (m_cnt == 2) m_csum = m_csum + m_cur.d;
`endif
            if (pop) begin
                m_cur = m_q.pop_front();
                m_cnt = 3;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
            if (wr) begin
                case (ix)
                    0: m_ctrl = bus.wbs_dat_i[1:0];
                    1: begin
                        if (lvl < 8 || pop) begin
                            e.a = bus.wbs_dat_i[15:8];
                            e.d = bus.wbs_dat_i[7:0];
                            m_q.push_back(e);
                            sb_q.push_back(e);
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    2: if (bus.wbs_dat_i[2]) m_ovf = 1'b0;
                    default: ;
                endcase
            end
            m_ack    = acc;
            m_ack_rd = acc && !wr;
        end
    end

    // Monitor: compares every cycle against the model, pops scoreboards on ack/strobe.
    always @(negedge clk) begin
        ent_t e;
        chk("ack", bus.wbs_ack_o, m_ack);
        if (bus.wbs_ack_o && m_ack_rd) begin
            if (rd_q.size() == 0) chk("rd_queue_empty", 1, 0);
            else chk("rdata", bus.wbs_dat_o, rd_q.pop_front());
        end else if (!bus.wbs_ack_o) begin
            chk("dat_idle", bus.wbs_dat_o, 0);
        end
        chk("strobe_timing", spm_ext_write, m_cnt == 2);
        chk("busy", busy, model_busy());
        chk("spm_rst", spm_rst, model_rst());
        if (m_cnt > 0) begin
            chk("addr_stable", spm_address, m_cur.a);
            chk("data_stable", spm_data, m_cur.d);
        end
        if (spm_ext_write) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_addr", spm_address, e.a);
                chk("sb_data", spm_data, e.d);
            end
        end
    end

    task automatic wb_xfer(input bit we, input logic [3:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wbs_ack_o && n < 8);
        chk("wb_ack_seen", bus.wbs_ack_o, 1);
        rdat = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [3:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (model_busy() && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", model_busy(), 0);
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (!spm_ext_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_seen", spm_ext_write, 1);
    endtask

    initial begin
        logic [31:0] d;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 4'h0;
        bus.wbs_dat_i = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_spm_rst", spm_rst, 1);
        chk("rst_ext_write", spm_ext_write, 0);
        chk("rst_address", spm_address, 0);
        chk("rst_data", spm_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", bus.wbs_ack_o, 0);
        rst_n = 1'b1;

        // Status after reset
        wb_xfer(1'b0, 4'h8, 32'h0, d);
        chk("t1_status", d, 32'h01);

        // Single entry
        wb_wr(4'h4, 32'h0000_12A5);
        wait_strobe();
        chk("t2_addr", spm_address, 8'h12);
        chk("t2_data", spm_data, 8'hA5);
        @(negedge clk);
        chk("t2_strobe_one_cycle", spm_ext_write, 0);
        wait_idle();
        chk("t2_busy_low", busy, 0);

        // Burst that outruns the drain rate and overflows
        for (int i = 0; i < 24; i++) begin
            wb_wr(4'h4, {$urandom_range(65535, 0), 8'(i + 8'h40), 8'($urandom)});
        end
        wb_xfer(1'b0, 4'h8, 32'h0, d);
        chk("t3_overflow", d[2], 1);
        wait_idle();
        wb_wr(4'h8, 32'h4);
        wb_xfer(1'b0, 4'h8, 32'h0, d);
        chk("t3_ovf_cleared", d, 32'h01);

        // Release while a load is in progress
        wb_wr(4'h0, 32'h0);
        for (int i = 0; i < 3; i++) wb_wr(4'h4, {16'h0, 8'(8'h80 + i), 8'($urandom)});
        wb_wr(4'h0, 32'h2);
        chk("t4_still_held", spm_rst, 1);
        wait_idle();
        chk("t4_released", spm_rst, 0);

        // Reset during a strobe
        wb_wr(4'h4, 32'h0000_3355);
        wb_wr(4'h4, 32'h0000_4466);
        wait_strobe();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ext_write", spm_ext_write, 0);
        chk("t5_address", spm_address, 0);
        chk("t5_data", spm_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_spm_rst", spm_rst, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wb_xfer(1'b0, 4'h8, 32'h0, d);
        chk("t5_status", d, 32'h01);

`ifdef SPM_LOADER_CSUM_EN
        wb_wr(4'hC, 32'h0);
        wb_wr(4'h4, 32'h0000_01F0);
        wb_wr(4'h4, 32'h0000_0220);
        wb_wr(4'h4, 32'h0000_0301);
        wait_idle();
        wb_xfer(1'b0, 4'hC, 32'h0, d);
        chk("t6_csum", d, 32'h11);
        wb_wr(4'hC, 32'h0);
        wb_xfer(1'b0, 4'hC, 32'h0, d);
        chk("t6_csum_clear", d, 32'h0);
`else
        wb_wr(4'hC, 32'hFF);
        wb_xfer(1'b0, 4'hC, 32'h0, d);
        chk("t6_csum_absent", d, 32'h0);
`endif

        // Random traffic
        for (int k = 0; k < 250; k++) begin
            int op;
            op = $urandom_range(11, 0);
            if (op <= 5) begin
                wb_wr(4'h4, $urandom);
            end else if (op <= 7) begin
                wb_xfer(1'b0, 4'($urandom), 32'h0, d);
            end else if (op == 8) begin
                wb_wr(4'h0, 32'($urandom_range(3, 0)));
            end else if (op == 9) begin
                wb_wr(4'h8, $urandom);
            end else if (op == 10) begin
                for (int j = 0; j < 14; j++) wb_wr(4'h4, $urandom);
            end else begin
                wb_wr(4'hC, $urandom);
            end
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("rd_drained", rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
